rob_retire: RTL and testbench

In-order retirement buffer at the back end of the pipeline: the release side of the rename free-pool protocol. Rename allocates a physical register for each destination and records the mapping it displaced. This block holds those records in program order, marks them complete when a functional unit finishes, and retires them one per cycle from the head. On each retirement it returns the displaced physical register to the free pool.

---
 rtl/rob_retire.sv | 127 ++++++++++++
 tb/tb_rob_retire.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// In-order retirement buffer: holds rename records in program order, marks them
// complete on functional-unit strobes and retires one per cycle from the head.
module rob_retire #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              alloc_valid,
    input  logic [AREG_W-1:0] alloc_dr,
    input  logic [PREG_W-1:0] alloc_dr_p,
    input  logic [PREG_W-1:0] alloc_old_p,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_idx,
    output logic              retire_valid,
    output logic [AREG_W-1:0] retire_dr,
    output logic [PREG_W-1:0] retire_dr_p,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    localparam logic [PREG_W-1:0] NO_MAP  = '1;
    localparam logic [IDX_W:0]    FULL_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]    PTR_ONE = (IDX_W+1)'(1);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [AREG_W-1:0] dr_q    [DEPTH];
    logic [PREG_W-1:0] dr_p_q  [DEPTH];
    logic [PREG_W-1:0] old_p_q [DEPTH];
    logic [IDX_W:0]    head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0]  head_idx, tail_idx;
    logic              alloc_fire, retire_fire, free_ok;

    logic              retire_valid_q, retire_valid_d;
    logic [AREG_W-1:0] retire_dr_q, retire_dr_d;
    logic [PREG_W-1:0] retire_dr_p_q, retire_dr_p_d;
    logic              free_valid_q, free_valid_d;
    logic [PREG_W-1:0] free_preg_q, free_preg_d;

    assign head_idx     = head_q[IDX_W-1:0];
    assign tail_idx     = tail_q[IDX_W-1:0];
    assign count        = tail_q - head_q;
    assign empty        = (count == '0);
    // No bypass of a same-cycle retire: a full buffer refuses allocation that cycle.
    assign alloc_ready  = (count != FULL_C);
    assign alloc_idx    = tail_idx;
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign retire_fire  = valid_q[head_idx] && done_q[head_idx];
    assign free_ok      = (dr_q[head_idx] != '0) && (old_p_q[head_idx] != NO_MAP);

    assign retire_valid = retire_valid_q;
    assign retire_dr    = retire_dr_q;
    assign retire_dr_p  = retire_dr_p_q;
    assign free_valid   = free_valid_q;
    assign free_preg    = free_preg_q;

    always_comb begin
        valid_d        = valid_q;
        done_d         = done_q;
        head_d         = head_q;
        tail_d         = tail_q;
        retire_valid_d = 1'b0;
        retire_dr_d    = retire_dr_q;
        retire_dr_p_d  = retire_dr_p_q;
        free_valid_d   = 1'b0;
        free_preg_d    = free_preg_q;
        // Completions only land on live entries; the tail slot is still invalid.
        if (cmpl_valid && valid_q[cmpl_idx]) begin
            done_d[cmpl_idx] = 1'b1;
        end
        if (retire_fire) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
            retire_valid_d    = 1'b1;
            retire_dr_d       = dr_q[head_idx];
            retire_dr_p_d     = dr_p_q[head_idx];
            free_valid_d      = free_ok;
            free_preg_d       = free_ok ? old_p_q[head_idx] : '0;
        end
        if (alloc_fire) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q        <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            retire_valid_q <= 1'b0;
            retire_dr_q    <= '0;
            retire_dr_p_q  <= '0;
            free_valid_q   <= 1'b0;
            free_preg_q    <= '0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            retire_valid_q <= retire_valid_d;
            retire_dr_q    <= retire_dr_d;
            retire_dr_p_q  <= retire_dr_p_d;
            free_valid_q   <= free_valid_d;
            free_preg_q    <= free_preg_d;
        end
    end

    // Payload is only read behind a set valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            dr_q[tail_idx]    <= alloc_dr;
            dr_p_q[tail_idx]  <= alloc_dr_p;
            old_p_q[tail_idx] <= alloc_old_p;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Randomized and directed bench for rob_retire: a program-order queue model predicts
// each retirement; a negedge monitor pops and compares against the DUT outputs.
module tb_rob_retire;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;
    localparam int EW     = 16 + AREG_W + PREG_W + 1 + PREG_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              alloc_valid = 1'b0;
    logic [AREG_W-1:0] alloc_dr = '0;
    logic [PREG_W-1:0] alloc_dr_p = '0;
    logic [PREG_W-1:0] alloc_old_p = '0;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_idx;
    logic              cmpl_valid = 1'b0;
    logic [IDX_W-1:0]  cmpl_idx = '0;
    logic              retire_valid;
    logic [AREG_W-1:0] retire_dr;
    logic [PREG_W-1:0] retire_dr_p;
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic [IDX_W:0]    count;
    logic              empty;

    rob_retire #(.DEPTH(DEPTH), .IDX_W(IDX_W), .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rstn(rstn),
        .alloc_valid(alloc_valid), .alloc_dr(alloc_dr), .alloc_dr_p(alloc_dr_p),
        .alloc_old_p(alloc_old_p), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
        .retire_valid(retire_valid), .retire_dr(retire_dr), .retire_dr_p(retire_dr_p),
        .free_valid(free_valid), .free_preg(free_preg), .count(count), .empty(empty)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    typedef struct {
        int               idx;
        logic [AREG_W-1:0] dr;
        logic [PREG_W-1:0] dr_p;
        logic [PREG_W-1:0] old_p;
        bit               done;
    } rec_t;

    rec_t           rob_m[$];
    int             tail_m = 0;
    logic [EW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [15:0]   now;
        now = cyc_cnt[15:0];
        while (exp_q.size() > 0 && exp_q[0][33:18] < now) begin
            e = exp_q.pop_front();
            chk("retire_missed", 32'd0, 32'd1);
        end
        if (exp_q.size() > 0 && exp_q[0][33:18] == now) begin
            e = exp_q.pop_front();
            chk("retire_valid", retire_valid, 1);
            chk("retire_dr", retire_dr, e[17:13]);
            chk("retire_dr_p", retire_dr_p, e[12:7]);
            chk("free_valid", free_valid, e[6]);
            chk("free_preg", free_preg, e[5:0]);
        end else begin
            chk("idle_pulses", {retire_valid, free_valid}, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit av, input logic [AREG_W-1:0] d, input logic [PREG_W-1:0] dp,
                         input logic [PREG_W-1:0] op, input bit cv, input logic [IDX_W-1:0] ci);
        int  sz;
        bit  retiring;
        bit  fv;
        rec_t r;
        @(negedge clk);
        #1;
        sz = rob_m.size();
        chk("count", count, sz);
        chk("empty", empty, sz == 0);
        chk("alloc_ready", alloc_ready, sz < DEPTH);
        chk("alloc_idx", alloc_idx, tail_m % DEPTH);
        alloc_valid = av; alloc_dr = d; alloc_dr_p = dp; alloc_old_p = op;
        cmpl_valid = cv; cmpl_idx = ci;
        // Predict the coming edge: head retires on its old done state, then completions.
        retiring = (sz > 0) && rob_m[0].done;
        if (cv) foreach (rob_m[i]) if (rob_m[i].idx == int'(ci)) rob_m[i].done = 1;
        if (retiring) begin
            r  = rob_m.pop_front();
            fv = (r.dr != 0) && (r.old_p != 6'd63);
            exp_q.push_back({16'(cyc_cnt + 1), r.dr, r.dr_p, fv, fv ? r.old_p : 6'd0});
        end
        if (av && sz < DEPTH) begin
            r.idx = tail_m % DEPTH; r.dr = d; r.dr_p = dp; r.old_p = op; r.done = 0;
            rob_m.push_back(r);
            tail_m++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, '0, '0, '0, 0, '0);
    endtask

    task automatic alloc(input logic [AREG_W-1:0] d, input logic [PREG_W-1:0] dp,
                         input logic [PREG_W-1:0] op);
        cycle(1, d, dp, op, 0, '0);
    endtask

    task automatic cmpl(input int ci);
        cycle(0, '0, '0, '0, 1, IDX_W'(ci));
    endtask

    task automatic drain();
        int guard = 0;
        int pick;
        while (rob_m.size() > 0 && guard < 200) begin
            pick = $urandom_range(0, rob_m.size() - 1);
            if (!rob_m[pick].done) cmpl(rob_m[pick].idx);
            else idle(1);
            guard++;
        end
        chk("drain_bound", rob_m.size(), 0);
        idle(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        alloc_valid = 0; alloc_dr = '0; alloc_dr_p = '0; alloc_old_p = '0;
        cmpl_valid = 0; cmpl_idx = '0;
        rob_m.delete(); tail_m = 0; exp_q.delete();
        #1;
        chk("rst_retire_valid", retire_valid, 0);
        chk("rst_retire_dr", retire_dr, 0);
        chk("rst_retire_dr_p", retire_dr_p, 0);
        chk("rst_free_valid", free_valid, 0);
        chk("rst_free_preg", free_preg, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_alloc_idx", alloc_idx, 0);
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        // Reset mid-stream with five live entries, two of them completed.
        for (int i = 0; i < 5; i++) alloc(AREG_W'(i + 1), PREG_W'(40 + i), PREG_W'(i + 1));
        cmpl(1);
        cmpl(3);
        do_reset();
        idle(4);

        // Single path.
        alloc(5'd3, 6'd33, 6'd3);
        cmpl(0);
        idle(4);

        // Out-of-order completion.
        do_reset();
        alloc(5'd1, 6'd41, 6'd1);
        alloc(5'd2, 6'd42, 6'd2);
        alloc(5'd4, 6'd44, 6'd4);
        cmpl(2);
        cmpl(1);
        idle(2);
        cmpl(0);
        idle(5);

        // Full buffer, dropped request, wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(AREG_W'(i + 1), PREG_W'(16 + i), PREG_W'(i));
        alloc(5'd9, 6'd9, 6'd9);
        cmpl(0);
        idle(2);
        chk("tail_wrap_bit", dut.tail_q[IDX_W], (tail_m / DEPTH) % 2);
        drain();

        // Entries that release nothing.
        do_reset();
        alloc(5'd0, 6'd20, 6'd5);
        alloc(5'd7, 6'd21, 6'd63);
        cmpl(0);
        cmpl(1);
        idle(4);

        // Same-edge allocate and retire; completions to unallocated slots.
        do_reset();
        for (int i = 0; i < 8; i++) alloc(AREG_W'(i + 10), PREG_W'(i + 30), PREG_W'(i + 2));
        cmpl(0);
        alloc(5'd20, 6'd50, 6'd12);
        idle(1);
        cycle(0, '0, '0, '0, 1, 4'd12);
        cycle(1, 5'd21, 6'd51, 6'd13, 1, IDX_W'(tail_m % DEPTH));
        idle(2);
        drain();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit               av, cv;
            logic [IDX_W-1:0] ci;
            logic [PREG_W-1:0] op;
            av = ($urandom_range(0, 9) < 6);
            cv = ($urandom_range(0, 9) < 7);
            if (rob_m.size() > 0 && $urandom_range(0, 3) != 0)
                ci = IDX_W'(rob_m[$urandom_range(0, rob_m.size() - 1)].idx);
            else
                ci = IDX_W'($urandom_range(0, DEPTH - 1));
            op = ($urandom_range(0, 7) == 0) ? 6'd63 : PREG_W'($urandom_range(0, 62));
            cycle(av, AREG_W'($urandom_range(0, 31)), PREG_W'($urandom_range(0, 63)), op, cv, ci);
        end
        drain();

        chk("exp_q_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
